// File: rtl/bw_clk_cl_rst_seq.sv
// ---------------------------------------------------------------------------
// bw_clk_cl_rst_seq
// Per-cluster clock-enable / reset / debug-init sequencer that sits directly
// upstream of the cluster header. Everything runs on the always-on gclk.
//
// Power-on: hold the cluster clock off, then enable it while holding reset,
// then release reset and debug-init. In RUN the block also services
// warm-reset and debug-init requests from the CTU using a req/ack handshake.
// It also services clock-stop requests.
//
// Ports
//   gclk          in   global clock, all state on posedge
//   arst          in   asynchronous reset, active-high
//   se            in   scan enable, ORed combinationally into cluster_cken
//   wrst_req      in   warm-reset request (level), acted on in RUN/STOP
//   dbg_req       in   debug-init request (level), acted on in RUN only
//   ckstop        in   clock-stop request, acted on in RUN only
//   cluster_cken  out  clock enable to the header (cken_q | se)
//   grst_l        out  registered synchronous reset, active-low
//   gdbginit_l    out  registered debug init, active-low
//   seq_ack       out  one-cycle pulse when a wrst/dbg operation completes
//   seq_busy      out  high whenever the sequencer is not in RUN
// ---------------------------------------------------------------------------
module bw_clk_cl_rst_seq #(
    parameter int CNT_W     = 8,
    parameter int CKOFF_CYC = 4,
    parameter int RST_HOLD  = 16,
    parameter int DBG_HOLD  = 8
) (
    input  logic gclk,
    input  logic arst,
    input  logic se,
    input  logic wrst_req,
    input  logic dbg_req,
    input  logic ckstop,
    output logic cluster_cken,
    output logic grst_l,
    output logic gdbginit_l,
    output logic seq_ack,
    output logic seq_busy
);

    typedef enum logic [2:0] {
        ST_CKOFF = 3'd0,
        ST_CKON  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRST  = 3'd3,
        ST_DBG   = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    // Hold-counter load values: a timed state lasting N cycles loads N-1.
    localparam logic [CNT_W-1:0] LD_CKOFF = CNT_W'(CKOFF_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_DBG   = CNT_W'(DBG_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cken_q, cken_d;
    logic             grst_l_q, grst_l_d;
    logic             gdbginit_l_q, gdbginit_l_d;
    logic             seq_ack_q, seq_ack_d;
    logic             seq_busy_q, seq_busy_d;
    logic             cnt_zero_s;

    assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});

    // Next-state and hold-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CKOFF: begin
                if (cnt_zero_s) begin
                    state_d = ST_CKON;
                    cnt_d   = LD_RST;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CKON, ST_WRST, ST_DBG: begin
                if (cnt_zero_s) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                // Fixed priority: warm reset over debug init over clock stop.
                if (wrst_req) begin
                    state_d = ST_WRST;
                    cnt_d   = LD_RST;
                end else if (dbg_req) begin
                    state_d = ST_DBG;
                    cnt_d   = LD_DBG;
                end else if (ckstop) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                // A warm reset may be started with the clock stopped; it
                // re-enables the clock through the WRST output decode.
                if (wrst_req) begin
                    state_d = ST_WRST;
                    cnt_d   = LD_RST;
                end else if (!ckstop) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_CKOFF;
                cnt_d   = LD_CKOFF;
            end
        endcase
    end

    // Output decode from the next state so that outputs are registered and
    // show each transition one gclk after the deciding edge.
    always_comb begin
        cken_d       = 1'b0;
        grst_l_d     = 1'b0;
        gdbginit_l_d = 1'b0;
        case (state_d)
            ST_CKOFF: begin cken_d = 1'b0; grst_l_d = 1'b0; gdbginit_l_d = 1'b0; end
            ST_CKON:  begin cken_d = 1'b1; grst_l_d = 1'b0; gdbginit_l_d = 1'b0; end
            ST_RUN:   begin cken_d = 1'b1; grst_l_d = 1'b1; gdbginit_l_d = 1'b1; end
            ST_WRST:  begin cken_d = 1'b1; grst_l_d = 1'b0; gdbginit_l_d = 1'b0; end
            ST_DBG:   begin cken_d = 1'b1; grst_l_d = 1'b1; gdbginit_l_d = 1'b0; end
            ST_STOP:  begin cken_d = 1'b0; grst_l_d = 1'b1; gdbginit_l_d = 1'b1; end
            default:  begin cken_d = 1'b0; grst_l_d = 1'b0; gdbginit_l_d = 1'b0; end
        endcase
        // Ack only on completion of a timed request operation, never on STOP exit.
        seq_ack_d  = ((state_q == ST_WRST) || (state_q == ST_DBG)) && (state_d == ST_RUN);
        seq_busy_d = (state_d != ST_RUN);
    end

    // State, counter and registered outputs; arst aborts any operation.
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_CKOFF;
            cnt_q        <= LD_CKOFF;
            cken_q       <= 1'b0;
            grst_l_q     <= 1'b0;
            gdbginit_l_q <= 1'b0;
            seq_ack_q    <= 1'b0;
            seq_busy_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cken_q       <= cken_d;
            grst_l_q     <= grst_l_d;
            gdbginit_l_q <= gdbginit_l_d;
            seq_ack_q    <= seq_ack_d;
            seq_busy_q   <= seq_busy_d;
        end
    end

    // Scan enable bypasses the sequencer so the header clocks during scan.
    assign cluster_cken = cken_q | se;
    assign grst_l       = grst_l_q;
    assign gdbginit_l   = gdbginit_l_q;
    assign seq_ack      = seq_ack_q;
    assign seq_busy     = seq_busy_q;

endmodule

// File: tb/tb_bw_clk_cl_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_bw_clk_cl_rst_seq
// Directed bench for bw_clk_cl_rst_seq. Each step pushes the expected output
// vector {cluster_cken, grst_l, gdbginit_l, seq_ack, seq_busy} onto a
// scoreboard queue. The step then advances one gclk edge, or applies async
// reset, and pops/compares the vector 1 time unit later.
// ---------------------------------------------------------------------------
module tb_bw_clk_cl_rst_seq;

    logic gclk = 1'b0;
    logic arst, se, wrst_req, dbg_req, ckstop;
    logic cluster_cken, grst_l, gdbginit_l, seq_ack, seq_busy;

    int compared   = 0;
    int mismatched = 0;
    logic [4:0] exp_q [$];

    // Expected vectors {cken, grst_l, gdbginit_l, ack, busy}
    localparam logic [4:0] V_CKOFF = 5'b00001;
    localparam logic [4:0] V_CKON  = 5'b10001;
    localparam logic [4:0] V_RUN   = 5'b11100;
    localparam logic [4:0] V_DBG   = 5'b11001;
    localparam logic [4:0] V_STOP  = 5'b01101;
    localparam logic [4:0] V_ACK   = 5'b11110;

    bw_clk_cl_rst_seq dut (
        .gclk         (gclk),
        .arst         (arst),
        .se           (se),
        .wrst_req     (wrst_req),
        .dbg_req      (dbg_req),
        .ckstop       (ckstop),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .seq_ack      (seq_ack),
        .seq_busy     (seq_busy)
    );

    always #5 gclk = ~gclk;

    function automatic logic [4:0] observed();
        return {cluster_cken, grst_l, gdbginit_l, seq_ack, seq_busy};
    endfunction

    task automatic check(input string tag);
        logic [4:0] e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: observed %b but scoreboard empty", tag, observed());
        end else begin
            e = exp_q.pop_front();
            assert (observed() === e) else begin
                mismatched++;
                $error("FAIL %s: observed %b expected %b", tag, observed(), e);
            end
        end
    endtask

    task automatic cycles(input int n, input logic [4:0] e, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            @(posedge gclk);
            #1;
            check(tag);
        end
    endtask

    task automatic check_now(input logic [4:0] e, input string tag);
        exp_q.push_back(e);
        #1;
        check(tag);
    endtask

    task automatic power_on(input string tag);
        @(negedge gclk);
        arst = 1'b0;
        cycles(3,  V_CKOFF, {tag, "_ckoff"});
        cycles(16, V_CKON,  {tag, "_ckon"});
        cycles(1,  V_RUN,   {tag, "_run"});
    endtask

    initial begin
        arst = 1'b1; se = 1'b0; wrst_req = 1'b0; dbg_req = 1'b0; ckstop = 1'b0;

        // T1 power-on
        #2;
        check_now(V_CKOFF, "t1_reset");
        power_on("t1");
        cycles(2, V_RUN, "t1_idle");

        // T2 warm reset, request dropped when ack is seen
        wrst_req = 1'b1;
        cycles(16, V_CKON, "t2_wrst");
        cycles(1,  V_ACK,  "t2_ack");
        wrst_req = 1'b0;
        cycles(2,  V_RUN,  "t2_after");

        // T3 debug init
        dbg_req = 1'b1;
        cycles(8, V_DBG, "t3_dbg");
        cycles(1, V_ACK, "t3_ack");
        dbg_req = 1'b0;
        cycles(1, V_RUN, "t3_after");

        // T3b simultaneous requests take the warm-reset path
        wrst_req = 1'b1; dbg_req = 1'b1;
        cycles(16, V_CKON, "t3b_wrst");
        cycles(1,  V_ACK,  "t3b_ack");
        wrst_req = 1'b0; dbg_req = 1'b0;
        cycles(1,  V_RUN,  "t3b_after");

        // T4 clock stop for 10 cycles, no ack on exit
        ckstop = 1'b1;
        cycles(10, V_STOP, "t4_stop");
        ckstop = 1'b0;
        cycles(2,  V_RUN,  "t4_resume");

        // T4b warm reset raised while stopped
        ckstop = 1'b1;
        cycles(3,  V_STOP, "t4b_stop");
        wrst_req = 1'b1;
        cycles(16, V_CKON, "t4b_wrst");
        cycles(1,  V_ACK,  "t4b_ack");
        wrst_req = 1'b0; ckstop = 1'b0;
        cycles(1,  V_RUN,  "t4b_after");

        // T5 async reset with the WRST counter at 7
        wrst_req = 1'b1;
        cycles(9, V_CKON, "t5_wrst");
        #3;
        arst = 1'b1;
        wrst_req = 1'b0;
        check_now(V_CKOFF, "t5_async");
        power_on("t5");
        cycles(1, V_RUN, "t5_idle");

        // T6 scan enable during CKOFF; state timing must match T1
        arst = 1'b1; se = 1'b1;
        check_now(V_CKON, "t6_se_reset");
        @(negedge gclk);
        arst = 1'b0;
        cycles(2,  V_CKON,  "t6_se_ckoff");
        se = 1'b0;
        cycles(1,  V_CKOFF, "t6_ckoff");
        cycles(16, V_CKON,  "t6_ckon");
        cycles(1,  V_RUN,   "t6_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
